// File: rtl/sally_bus_arbiter.sv
// CPU-side responder to MARIA's halt/ready/interrupt handshake: produces the T65 clock enable,
// RDY and NMI, releases the bus only at a read-cycle boundary, and counts stall cycles.
module sally_bus_arbiter #(
   parameter int MAX_WRITES = 3,
   parameter int NMI_HOLD   = 2,
   parameter int CNT_W      = 13
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             pclk0,
   input  logic             pclk1,
   input  logic             halt_b,
   input  logic             ready,
   input  logic             int_b,
   input  logic             cpu_rw,
   input  logic             line_clr,
   output logic             cpu_ce,
   output logic             cpu_rdy,
   output logic             cpu_nmi_n,
   output logic             bus_release,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WC_W = (MAX_WRITES < 1) ? 1 : $clog2(MAX_WRITES + 1);
   localparam int NH_W = (NMI_HOLD < 1) ? 1 : $clog2(NMI_HOLD + 1);

   localparam logic [WC_W-1:0] C_MAX_WR = WC_W'(MAX_WRITES);
   localparam logic [WC_W-1:0] C_WR_ONE = WC_W'(1);
   localparam logic [NH_W-1:0] C_NMI_LD = NH_W'(NMI_HOLD);
   localparam logic [NH_W-1:0] C_NMI_ONE = NH_W'(1);
   localparam logic [CNT_W-1:0] C_STALL_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED,
      ST_RESUME
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WC_W-1:0]   r_wr_cnt;
   logic [WC_W-1:0]   w_wr_cnt_nxt;
   logic [WC_W-1:0]   w_wr_cnt_inc;
   logic              r_ce;
   logic              r_rdy;
   logic              r_int_q;
   logic [NH_W-1:0]   r_nmi_cnt;
   logic [CNT_W-1:0]  r_stall;

   logic              w_cpu_active;
   logic              w_stalled;
   logic              w_pclk0_only;
   logic              w_int_fall;
   logic              w_stall_inc;

   assign w_cpu_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   // A read waits on ready; writes always complete, as on the NMOS part.
   assign w_stalled    = ~ready & cpu_rw;
   assign w_wr_cnt_inc = r_wr_cnt + C_WR_ONE;
   assign w_pclk0_only = pclk0 & ~pclk1;
   assign w_int_fall   = w_pclk0_only & r_int_q & ~int_b;
   assign w_stall_inc  = pclk1 & ((r_state == ST_HALTED) || (r_state == ST_RESUME) ||
                                  (w_cpu_active && w_stalled));

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_wr_cnt_nxt = r_wr_cnt;
      if (pclk1) begin
         unique case (r_state)
            ST_RUN: begin
               if (!halt_b) begin
                  if (cpu_rw || (C_WR_ONE >= C_MAX_WR)) begin
                     w_state_nxt  = ST_HALTED;
                     w_wr_cnt_nxt = '0;
                  end else begin
                     w_state_nxt  = ST_DRAIN;
                     w_wr_cnt_nxt = C_WR_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (halt_b) begin
                  w_state_nxt  = ST_RUN;
                  w_wr_cnt_nxt = '0;
               end else if (cpu_rw || (w_wr_cnt_inc >= C_MAX_WR)) begin
                  // Read boundary reached, or the RMW/BRK write burst is exhausted.
                  w_state_nxt  = ST_HALTED;
                  w_wr_cnt_nxt = '0;
               end else begin
                  w_wr_cnt_nxt = w_wr_cnt_inc;
               end
            end
            ST_HALTED: begin
               if (halt_b) w_state_nxt = ST_RESUME;
            end
            ST_RESUME: begin
               w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt  = ST_RUN;
               w_wr_cnt_nxt = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so every register samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state  <= ST_RUN;
         r_wr_cnt <= '0;
         r_ce     <= 1'b0;
         r_rdy    <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_cnt <= w_wr_cnt_nxt;
         r_ce     <= pclk1 & w_cpu_active & ~w_stalled;
         if (pclk1 && (r_state != ST_HALTED)) r_rdy <= ready;
      end
   end

   // NMI hold only counts executed CPU cycles, so a halt never shortens it.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_int_q   <= 1'b1;
         r_nmi_cnt <= '0;
      end else begin
         if (w_pclk0_only) r_int_q <= int_b;
         if (w_int_fall) begin
            r_nmi_cnt <= C_NMI_LD;
         end else if (r_ce && (r_nmi_cnt != '0)) begin
            r_nmi_cnt <= r_nmi_cnt - C_NMI_ONE;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_stall <= '0;
      end else if (line_clr) begin
         r_stall <= '0;
      end else if (w_stall_inc && (r_stall != '1)) begin
         r_stall <= r_stall + C_STALL_ONE;
      end
   end

   assign cpu_ce       = r_ce;
   assign cpu_rdy      = r_rdy;
   assign cpu_nmi_n    = (r_nmi_cnt == '0);
   assign bus_release  = (r_state == ST_HALTED);
   assign stall_cycles = r_stall;

endmodule

// File: tb/tb_sally_bus_arbiter.sv
// Scoreboard bench for sally_bus_arbiter: each expected cpu_ce pulse is queued with the
// status outputs it should coincide with; a monitor pops and compares on every pulse.
module tb_sally_bus_arbiter;

   localparam int CNT_W = 13;

   logic             clk_sys = 1'b0;
   logic             reset = 1'b1;
   logic             pclk0 = 1'b0;
   logic             pclk1 = 1'b0;
   logic             halt_b = 1'b1;
   logic             ready = 1'b1;
   logic             int_b = 1'b1;
   logic             cpu_rw = 1'b1;
   logic             line_clr = 1'b0;
   logic             cpu_ce;
   logic             cpu_rdy;
   logic             cpu_nmi_n;
   logic             bus_release;
   logic [CNT_W-1:0] stall_cycles;

   typedef struct {
      int   idx;
      logic rel;
      logic rdy;
      logic nmi_n;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   pclk1_idx = 0;
   logic pclk1_seen = 1'b0;

   sally_bus_arbiter #(.MAX_WRITES(3), .NMI_HOLD(2), .CNT_W(CNT_W)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .pclk0        (pclk0),
      .pclk1        (pclk1),
      .halt_b       (halt_b),
      .ready        (ready),
      .int_b        (int_b),
      .cpu_rw       (cpu_rw),
      .line_clr     (line_clr),
      .cpu_ce       (cpu_ce),
      .cpu_rdy      (cpu_rdy),
      .cpu_nmi_n    (cpu_nmi_n),
      .bus_release  (bus_release),
      .stall_cycles (stall_cycles)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) pclk1_seen <= pclk1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every cpu_ce pulse must match the oldest queued expectation.
   always @(negedge clk_sys) begin
      if (!reset && cpu_ce) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ce_unexpected: got ce at pclk1 #%0d want none (t=%0t)", pclk1_idx, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("ce_cycle", pclk1_idx, e.idx);
            check("ce_latency", pclk1_seen, 1);
            check("ce_bus_release", bus_release, e.rel);
            check("ce_cpu_rdy", cpu_rdy, e.rdy);
            check("ce_nmi_n", cpu_nmi_n, e.nmi_n);
         end
      end
   end

   // One CPU cycle: pclk0 on the first clk, pclk1 on the fourth. The pclk1 edge itself
   // happens at the start of the next call (or settle), which drops pclk1 again.
   task automatic cyc(input logic hb, input logic rdy, input logic rw, input logic ib,
                      input logic exp_ce, input logic exp_rel, input logic exp_nmi);
      exp_t e;
      @(posedge clk_sys); #1;
      pclk1 = 1'b0; pclk0 = 1'b1;
      int_b = ib; halt_b = hb; ready = rdy; cpu_rw = rw;
      @(posedge clk_sys); #1;
      pclk0 = 1'b0;
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      pclk1 = 1'b1;
      pclk1_idx++;
      if (exp_ce) begin
         e.idx = pclk1_idx; e.rel = exp_rel; e.rdy = rdy; e.nmi_n = exp_nmi;
         sb_q.push_back(e);
      end
   endtask

   task automatic settle();
      @(posedge clk_sys); #1;
      pclk1 = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      check("sb_drained", sb_q.size(), 0);
   endtask

   task automatic clear_stall();
      @(posedge clk_sys); #1; line_clr = 1'b1;
      @(posedge clk_sys); #1; line_clr = 1'b0;
      check("line_clr", stall_cycles, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      check("rst_ce", cpu_ce, 0);
      check("rst_rdy", cpu_rdy, 1);
      check("rst_nmi_n", cpu_nmi_n, 1);
      check("rst_bus_release", bus_release, 0);
      check("rst_stall", stall_cycles, 0);
      reset = 1'b0;

      // 1: free-running reads
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t1_release", bus_release, 0);
      check("t1_stall", stall_cycles, 0);

      // 2: halt on a read, three halted cycles, one RESUME cycle
      cyc(0, 1, 1, 1, 1, 1, 1);
      cyc(0, 1, 1, 1, 0, 0, 1);
      cyc(0, 1, 1, 1, 0, 0, 1);
      check("t2_release_mid", bus_release, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t2_stall", stall_cycles, 4);
      clear_stall();

      // 3a: three writes exhaust the write budget
      cyc(0, 1, 0, 1, 1, 0, 1);
      cyc(0, 1, 0, 1, 1, 0, 1);
      cyc(0, 1, 0, 1, 1, 1, 1);
      cyc(0, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t3a_stall", stall_cycles, 3);
      clear_stall();

      // 3b: two writes then a read
      cyc(0, 1, 0, 1, 1, 0, 1);
      cyc(0, 1, 0, 1, 1, 0, 1);
      cyc(0, 1, 1, 1, 1, 1, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t3b_stall", stall_cycles, 2);
      clear_stall();

      // 3c: halt withdrawn while draining writes
      cyc(0, 1, 0, 1, 1, 0, 1);
      cyc(1, 1, 0, 1, 1, 0, 1);
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t3c_release", bus_release, 0);
      check("t3c_stall", stall_cycles, 0);

      // 4: five ready-stalled reads, then a write ignores ready
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 0, 0, 1);
      settle();
      check("t4_rdy", cpu_rdy, 0);
      check("t4_stall", stall_cycles, 5);
      cyc(1, 0, 0, 1, 1, 0, 1);
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();
      check("t4_rdy_back", cpu_rdy, 1);
      check("t4_stall_after_write", stall_cycles, 5);
      clear_stall();

      // 5: NMI arrives while halted and survives until two ce pulses after resume
      cyc(0, 1, 1, 1, 1, 1, 1);
      cyc(0, 1, 1, 0, 0, 0, 1);
      cyc(0, 1, 1, 0, 0, 0, 1);
      check("t5_nmi_in_halt", cpu_nmi_n, 0);
      cyc(1, 1, 1, 0, 0, 0, 1);
      cyc(1, 1, 1, 0, 0, 0, 1);
      check("t5_nmi_in_resume", cpu_nmi_n, 0);
      cyc(1, 1, 1, 0, 1, 0, 0);
      cyc(1, 1, 1, 0, 1, 0, 0);
      settle();
      check("t5_nmi_released", cpu_nmi_n, 1);
      check("t5_stall", stall_cycles, 4);
      clear_stall();
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();

      // 6: saturate stall_cycles while halted, then reset mid-halt
      cyc(0, 1, 1, 1, 1, 1, 1);
      @(posedge clk_sys); #1;
      pclk1 = 1'b0;
      for (int i = 0; i < 8200; i++) begin
         @(posedge clk_sys); #1; pclk1 = 1'b1;
         @(posedge clk_sys); #1; pclk1 = 1'b0;
      end
      check("t6_stall_saturated", stall_cycles, 8191);
      check("t6_release_before_rst", bus_release, 1);
      @(posedge clk_sys); #1; reset = 1'b1;
      @(posedge clk_sys); #1;
      check("t6_rst_release", bus_release, 0);
      check("t6_rst_stall", stall_cycles, 0);
      reset = 1'b0;
      halt_b = 1'b1;
      cyc(1, 1, 1, 1, 1, 0, 1);
      settle();

      // line_clr beats an increment in the same clock
      cyc(1, 0, 1, 1, 0, 0, 1);
      settle();
      check("t6_stall_one", stall_cycles, 1);
      line_clr = 1'b1;
      cyc(1, 0, 1, 1, 0, 0, 1);
      @(posedge clk_sys); #1;
      line_clr = 1'b0;
      pclk1 = 1'b0;
      check("t6_clr_priority", stall_cycles, 0);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
